// File: rtl/fc_pkg.sv
// fc_pkg: shared widths, FSM state type and 16-bit output saturation for the FC score unit.
package fc_pkg;

    localparam int N_CLASSES = 10;
    localparam int DATA_W    = 16;
    localparam int FRAC_BITS = 11;
    localparam int ACC_W     = 40;

    localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'(32767);
    localparam logic signed [ACC_W-1:0] SAT_MIN = ACC_W'(-32768);

    typedef enum logic [2:0] {IDLE, LOAD, MAC, BIAS_RD, BIAS_ADD, DONE} state_e;

    function automatic logic [DATA_W-1:0] sat16(input logic signed [ACC_W-1:0] v);
        return v > SAT_MAX ? 16'h7FFF : v < SAT_MIN ? 16'h8000 : v[DATA_W-1:0];
    endfunction

endpackage

// File: rtl/fc_mac_lane.sv
// fc_mac_lane: one class accumulator; clears, adds a full product or the scaled bias,
// and presents the saturated score of the value being written this cycle.
module fc_mac_lane
    import fc_pkg::*;
(
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     clear_i,
    input  logic                     mac_en_i,
    input  logic                     bias_en_i,
    input  logic signed [DATA_W-1:0] act_i,
    input  logic signed [DATA_W-1:0] weight_i,
    input  logic signed [DATA_W-1:0] bias_i,
    output logic [DATA_W-1:0]        sat_o
);

    logic signed [2*DATA_W-1:0] prod;
    logic signed [ACC_W-1:0]    prod_ext;
    logic signed [ACC_W-1:0]    bias_ext;
    logic signed [ACC_W-1:0]    acc_q;
    logic signed [ACC_W-1:0]    acc_d;

    assign prod     = act_i * weight_i;
    assign prod_ext = {{(ACC_W-2*DATA_W){prod[2*DATA_W-1]}}, prod};
    assign bias_ext = {{(ACC_W-DATA_W-FRAC_BITS){bias_i[DATA_W-1]}}, bias_i, {FRAC_BITS{1'b0}}};

    always_comb acc_d = clear_i   ? '0 :
                        mac_en_i  ? acc_q + prod_ext :
                        bias_en_i ? acc_q + bias_ext : acc_q;

    // Saturating from acc_d lets the top capture the biased score on the same edge the bias lands.
    assign sat_o = sat16(acc_d >>> FRAC_BITS);

    always_ff @(posedge clk or posedge reset)
        if (reset) acc_q <= '0;
        else       acc_q <= acc_d;

endmodule

// File: rtl/fc_score_unit.sv
// fc_score_unit: final FC layer; streams N_IN activations against 10-wide weight rows,
// adds per-class bias and emits ten saturated Q5.11 scores with a one-cycle done pulse.
module fc_score_unit
    import fc_pkg::*;
#(
    parameter int N_IN   = 84,
    parameter int ADDR_W = $clog2(N_IN + 1)
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          enable,
    input  logic                          act_valid,
    input  logic [DATA_W-1:0]             act_data,
    output logic                          act_ready,
    output logic [ADDR_W-1:0]             w_addr,
    input  logic [N_CLASSES*DATA_W-1:0]   w_data,
    output logic [DATA_W-1:0]             out0,
    output logic [DATA_W-1:0]             out1,
    output logic [DATA_W-1:0]             out2,
    output logic [DATA_W-1:0]             out3,
    output logic [DATA_W-1:0]             out4,
    output logic [DATA_W-1:0]             out5,
    output logic [DATA_W-1:0]             out6,
    output logic [DATA_W-1:0]             out7,
    output logic [DATA_W-1:0]             out8,
    output logic [DATA_W-1:0]             out9,
    output logic                          done,
    output logic                          busy
);

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   cnt_q, cnt_d;
    logic [DATA_W-1:0]   act_q, act_d;
    logic [DATA_W-1:0]   out_q [N_CLASSES];
    logic [DATA_W-1:0]   out_d [N_CLASSES];
    logic [DATA_W-1:0]   sat   [N_CLASSES];
    logic                last, start, hs;

    assign last      = cnt_q == ADDR_W'(N_IN - 1);
    assign start     = state_q == IDLE && enable;
    assign act_ready = state_q == LOAD;
    assign hs        = act_valid && act_ready;
    assign busy      = state_q != IDLE;
    assign done      = state_q == DONE;
    assign w_addr    = state_q == BIAS_RD ? ADDR_W'(N_IN) : cnt_q;

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:     state_d = enable ? LOAD : IDLE;
            LOAD:     state_d = hs ? MAC : LOAD;
            MAC:      state_d = last ? BIAS_RD : LOAD;
            BIAS_RD:  state_d = BIAS_ADD;
            BIAS_ADD: state_d = DONE;
            DONE:     state_d = IDLE;
            default:  state_d = IDLE;
        endcase
    end

    assign cnt_d = start ? '0 : (state_q == MAC && !last) ? cnt_q + 1'b1 : cnt_q;
    assign act_d = hs ? act_data : act_q;

    always_comb
        for (int k = 0; k < N_CLASSES; k++)
            out_d[k] = state_q == BIAS_ADD ? sat[k] : out_q[k];

    // The same row lane feeds weight during MAC and bias during BIAS_ADD (row N_IN).
    for (genvar g = 0; g < N_CLASSES; g++) begin : g_lane
        fc_mac_lane u_lane (
            .clk       (clk),
            .reset     (reset),
            .clear_i   (start),
            .mac_en_i  (state_q == MAC),
            .bias_en_i (state_q == BIAS_ADD),
            .act_i     (act_q),
            .weight_i  (w_data[g*DATA_W +: DATA_W]),
            .bias_i    (w_data[g*DATA_W +: DATA_W]),
            .sat_o     (sat[g])
        );
    end

    always_ff @(posedge clk or posedge reset)
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            act_q   <= '0;
            for (int k = 0; k < N_CLASSES; k++) out_q[k] <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            act_q   <= act_d;
            for (int k = 0; k < N_CLASSES; k++) out_q[k] <= out_d[k];
        end

    assign out0 = out_q[0];
    assign out1 = out_q[1];
    assign out2 = out_q[2];
    assign out3 = out_q[3];
    assign out4 = out_q[4];
    assign out5 = out_q[5];
    assign out6 = out_q[6];
    assign out7 = out_q[7];
    assign out8 = out_q[8];
    assign out9 = out_q[9];

endmodule
